t5_wbarb: RTL and testbench



---
 rtl/t5_pkg.sv | 16 +
 rtl/t5_wbarb.sv | 173 +++++++++++++++++
 tb/tb_t5_wbarb.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/t5_pkg.sv
// Shared definitions for the t5 Wishbone arbiter.
// Holds the arbiter state encoding and the grant codes driven on arb_gnt.
// arb_gnt mirrors the state, so the two encodings line up bit for bit.
package t5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IBUS = 2'd1,
        ST_DBUS = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

endpackage : t5_pkg

// File: rtl/t5_wbarb.sv
// t5_wbarb: two-master Wishbone arbiter sharing one memory port between the
// instruction port (iwb) and the data port (dwb) of the t5 core.
//
// Ports
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   iwb_*                   instruction master (read-only; iwb_wre ignored)
//   dwb_*                   data master
//   mwb_*                   shared slave port (combinational mux of the owner)
//   arb_gnt                 current owner: 00 none, 01 instruction, 10 data
//   arb_tmo                 sticky watchdog flag, cleared only by reset
//
// Handshake: a master holds its stb high until it sees its ack. The owner's
// ack is mwb_ack passed straight through in the same cycle; dropping stb
// before ack abandons the transaction. Data wins ties unless the instruction
// port has waited through DSTARVE consecutive data grants. The watchdog ends
// a grant after TIMEOUT cycles without mwb_ack and acks the owner with zero
// data. Every transaction is followed by one IDLE cycle.
module t5_wbarb
    import t5_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DSTARVE = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            sys_clk,
    input  logic            sys_rst,

    input  logic [31:2]     iwb_adr,
    input  logic            iwb_stb,
    input  logic [3:0]      iwb_sel,
    input  logic            iwb_wre,
    output logic            iwb_ack,
    output logic [31:0]     iwb_dat,

    input  logic [31:2]     dwb_adr,
    input  logic [XLEN-1:0] dwb_dto,
    input  logic [3:0]      dwb_sel,
    input  logic            dwb_stb,
    input  logic            dwb_wre,
    output logic            dwb_ack,
    output logic [XLEN-1:0] dwb_dti,

    output logic [31:2]     mwb_adr,
    output logic [XLEN-1:0] mwb_dto,
    output logic [3:0]      mwb_sel,
    output logic            mwb_stb,
    output logic            mwb_wre,
    input  logic            mwb_ack,
    input  logic [XLEN-1:0] mwb_dti,

    output logic [1:0]      arb_gnt,
    output logic            arb_tmo
);

    localparam logic [3:0] DSTARVE_C = 4'(DSTARVE);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
    localparam bit         TMO_EN    = (TIMEOUT != 0);

    arb_state_e state_q, state_d;
    logic [3:0] dcnt_q, dcnt_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       tmo_q, tmo_d;

    logic       granted;
    logic       owner_stb;
    logic       starving;
    logic       tmo_fire;

    // The instruction port never writes; its write-enable is left unused.
    logic unused_iwb_wre;
    assign unused_iwb_wre = iwb_wre;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            dcnt_q  <= 4'd0;
            tcnt_q  <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            tcnt_q  <= tcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        tcnt_d    = tcnt_q;
        tmo_d     = tmo_q;

        granted   = (state_q != ST_IDLE);
        owner_stb = 1'b0;
        if (state_q == ST_IBUS) owner_stb = iwb_stb;
        if (state_q == ST_DBUS) owner_stb = dwb_stb;

        starving  = iwb_stb && (dcnt_q == DSTARVE_C);
        // An owner abort takes precedence over the watchdog in the same cycle.
        tmo_fire  = TMO_EN && granted && owner_stb && !mwb_ack && (tcnt_q == TMO_LAST);

        mwb_adr   = '0;
        mwb_dto   = '0;
        mwb_sel   = '0;
        mwb_stb   = 1'b0;
        mwb_wre   = 1'b0;
        iwb_ack   = 1'b0;
        iwb_dat   = '0;
        dwb_ack   = 1'b0;
        dwb_dti   = '0;

        // Shared port mux; the instruction side drives no write data.
        case (state_q)
            ST_IBUS: begin
                mwb_adr = iwb_adr;
                mwb_sel = iwb_sel;
                mwb_stb = iwb_stb && !tmo_fire;
                iwb_ack = iwb_stb && (mwb_ack || tmo_fire);
                if (iwb_stb && mwb_ack) iwb_dat = mwb_dti;
            end
            ST_DBUS: begin
                mwb_adr = dwb_adr;
                mwb_dto = dwb_dto;
                mwb_sel = dwb_sel;
                mwb_wre = dwb_wre;
                mwb_stb = dwb_stb && !tmo_fire;
                dwb_ack = dwb_stb && (mwb_ack || tmo_fire);
                if (dwb_stb && mwb_ack) dwb_dti = mwb_dti;
            end
            default: ;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (dwb_stb && !starving) begin
                    state_d = ST_DBUS;
                end else if (iwb_stb) begin
                    state_d = ST_IBUS;
                end
            end
            ST_IBUS, ST_DBUS: begin
                if (!owner_stb || mwb_ack || tmo_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Starvation counter: counts data completions while fetch waits.
        if (state_q == ST_DBUS && dwb_stb && mwb_ack) begin
            if (!iwb_stb) begin
                dcnt_d = 4'd0;
            end else if (dcnt_q != DSTARVE_C) begin
                dcnt_d = dcnt_q + 4'd1;
            end
        end else if (state_q == ST_IBUS && iwb_stb && mwb_ack) begin
            dcnt_d = 4'd0;
        end

        // Watchdog counter; saturates so a disabled watchdog never wraps.
        if (state_q == ST_IDLE) begin
            if (state_d != ST_IDLE) tcnt_d = 8'd0;
        end else if (!mwb_ack && tcnt_q != 8'hFF) begin
            tcnt_d = tcnt_q + 8'd1;
        end

        if (tmo_fire) tmo_d = 1'b1;
    end

    assign arb_gnt = state_q;
    assign arb_tmo = tmo_q;

endmodule : t5_wbarb

// File: tb/tb_t5_wbarb.sv
// Directed testbench for t5_wbarb (DSTARVE=4, TIMEOUT=8).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 time unit later, well before the falling edge.
module tb_t5_wbarb;

    localparam int XLEN = 32;

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic [31:2]     iwb_adr = '0;
    logic            iwb_stb = 1'b0;
    logic [3:0]      iwb_sel = '0;
    logic            iwb_wre = 1'b0;
    logic            iwb_ack;
    logic [31:0]     iwb_dat;
    logic [31:2]     dwb_adr = '0;
    logic [XLEN-1:0] dwb_dto = '0;
    logic [3:0]      dwb_sel = '0;
    logic            dwb_stb = 1'b0;
    logic            dwb_wre = 1'b0;
    logic            dwb_ack;
    logic [XLEN-1:0] dwb_dti;
    logic [31:2]     mwb_adr;
    logic [XLEN-1:0] mwb_dto;
    logic [3:0]      mwb_sel;
    logic            mwb_stb;
    logic            mwb_wre;
    logic            mwb_ack;
    logic [XLEN-1:0] mwb_dti = '0;
    logic [1:0]      arb_gnt;
    logic            arb_tmo;

    // Slave model: either a manual ack, or an immediate ack whenever a
    // master holds the bus (derived from the registered grant, no loop).
    logic man_ack  = 1'b0;
    logic auto_ack = 1'b0;
    assign mwb_ack = man_ack | (auto_ack & (arb_gnt != 2'b00));

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    t5_wbarb #(.XLEN(XLEN), .DSTARVE(4), .TIMEOUT(8)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_sel(iwb_sel), .iwb_wre(iwb_wre),
        .iwb_ack(iwb_ack), .iwb_dat(iwb_dat),
        .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel), .dwb_stb(dwb_stb),
        .dwb_wre(dwb_wre), .dwb_ack(dwb_ack), .dwb_dti(dwb_dti),
        .mwb_adr(mwb_adr), .mwb_dto(mwb_dto), .mwb_sel(mwb_sel), .mwb_stb(mwb_stb),
        .mwb_wre(mwb_wre), .mwb_ack(mwb_ack), .mwb_dti(mwb_dti),
        .arb_gnt(arb_gnt), .arb_tmo(arb_tmo)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] starve_exp [12];
        starve_exp = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0,
                       2'd1, 2'd0, 2'd2, 2'd0};

        // Reset
        step();
        #1;
        chk("rst_gnt", 32'(arb_gnt), 32'd0);
        chk("rst_stb", 32'(mwb_stb), 32'd0);
        chk("rst_tmo", 32'(arb_tmo), 32'd0);
        chk("rst_iack", 32'(iwb_ack), 32'd0);
        chk("rst_dack", 32'(dwb_ack), 32'd0);
        step();
        sys_rst = 1'b0;

        // Instruction only, slave acks 2 cycles after strobe
        step();
        iwb_stb = 1'b1; iwb_adr = 30'h40; iwb_sel = 4'hF;
        #1;
        chk("i_idle_stb", 32'(mwb_stb), 32'd0);
        step();
        chk("i_c1_gnt", 32'(arb_gnt), 32'd1);
        chk("i_c1_stb", 32'(mwb_stb), 32'd1);
        chk("i_c1_adr", 32'(mwb_adr), 32'h40);
        chk("i_c1_wre", 32'(mwb_wre), 32'd0);
        chk("i_c1_ack", 32'(iwb_ack), 32'd0);
        step();
        chk("i_c2_gnt", 32'(arb_gnt), 32'd1);
        chk("i_c2_ack", 32'(iwb_ack), 32'd0);
        step();
        man_ack = 1'b1; mwb_dti = 32'h0000_0013;
        #1;
        chk("i_c3_gnt", 32'(arb_gnt), 32'd1);
        chk("i_c3_ack", 32'(iwb_ack), 32'd1);
        chk("i_c3_dat", iwb_dat, 32'h13);
        step();
        man_ack = 1'b0; iwb_stb = 1'b0;
        #1;
        chk("i_end_gnt", 32'(arb_gnt), 32'd0);
        chk("i_end_ack", 32'(iwb_ack), 32'd0);
        chk("i_end_dat", iwb_dat, 32'd0);

        // Simultaneous requests: data first, then instruction
        iwb_stb = 1'b1; iwb_adr = 30'h41;
        dwb_stb = 1'b1; dwb_wre = 1'b1; dwb_adr = 30'h80;
        dwb_dto = 32'hDEAD_BEEF; dwb_sel = 4'hF;
        step();
        chk("s_d_gnt", 32'(arb_gnt), 32'd2);
        chk("s_d_wre", 32'(mwb_wre), 32'd1);
        chk("s_d_dto", mwb_dto, 32'hDEAD_BEEF);
        chk("s_d_adr", 32'(mwb_adr), 32'h80);
        chk("s_d_sel", 32'(mwb_sel), 32'hF);
        man_ack = 1'b1; mwb_dti = 32'h1234_5678;
        #1;
        chk("s_d_dack", 32'(dwb_ack), 32'd1);
        chk("s_d_iack", 32'(iwb_ack), 32'd0);
        step();
        man_ack = 1'b0; dwb_stb = 1'b0; dwb_wre = 1'b0;
        #1;
        chk("s_turn_gnt", 32'(arb_gnt), 32'd0);
        chk("s_turn_dack", 32'(dwb_ack), 32'd0);
        step();
        chk("s_i_gnt", 32'(arb_gnt), 32'd1);
        chk("s_i_adr", 32'(mwb_adr), 32'h41);
        chk("s_i_wre", 32'(mwb_wre), 32'd0);
        chk("s_i_dto", mwb_dto, 32'd0);
        man_ack = 1'b1; mwb_dti = 32'h0000_0055;
        #1;
        chk("s_i_iack", 32'(iwb_ack), 32'd1);
        chk("s_i_dack", 32'(dwb_ack), 32'd0);
        chk("s_i_dat", iwb_dat, 32'h55);
        chk("s_i_ddti", dwb_dti, 32'd0);
        step();
        man_ack = 1'b0; iwb_stb = 1'b0;
        #1;
        chk("s_end_gnt", 32'(arb_gnt), 32'd0);

        // Starvation: data held, fetch pending, immediate acks
        auto_ack = 1'b1; dwb_stb = 1'b1; iwb_stb = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("starve_gnt%0d", i), 32'(arb_gnt), 32'(starve_exp[i]));
            chk($sformatf("starve_overlap%0d", i), 32'(iwb_ack & dwb_ack), 32'd0);
        end
        auto_ack = 1'b0; dwb_stb = 1'b0; iwb_stb = 1'b0;
        step();
        chk("starve_end_gnt", 32'(arb_gnt), 32'd0);

        // Watchdog: data read never acked
        dwb_stb = 1'b1; dwb_adr = 30'h90; mwb_dti = 32'hFFFF_FFFF;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk($sformatf("wd_stb%0d", c), 32'(mwb_stb), 32'd1);
            chk($sformatf("wd_ack%0d", c), 32'(dwb_ack), 32'd0);
        end
        step();
        chk("wd_fire_stb", 32'(mwb_stb), 32'd0);
        chk("wd_fire_ack", 32'(dwb_ack), 32'd1);
        chk("wd_fire_dti", dwb_dti, 32'd0);
        chk("wd_fire_tmo", 32'(arb_tmo), 32'd0);
        step();
        dwb_stb = 1'b0;
        #1;
        chk("wd_tmo_set", 32'(arb_tmo), 32'd1);
        chk("wd_gnt_idle", 32'(arb_gnt), 32'd0);
        step();
        step();
        chk("wd_tmo_sticky", 32'(arb_tmo), 32'd1);

        // Abort: data drops stb on the 2nd granted cycle
        dwb_stb = 1'b1;
        step();
        chk("ab_c1_stb", 32'(mwb_stb), 32'd1);
        step();
        dwb_stb = 1'b0;
        #1;
        chk("ab_c2_stb", 32'(mwb_stb), 32'd0);
        chk("ab_c2_ack", 32'(dwb_ack), 32'd0);
        step();
        chk("ab_gnt", 32'(arb_gnt), 32'd0);

        // Reset in the middle of a data transaction
        dwb_stb = 1'b1; dwb_adr = 30'hA0;
        step();
        chk("rm_gnt", 32'(arb_gnt), 32'd2);
        sys_rst = 1'b1;
        #1;
        chk("rm_stb", 32'(mwb_stb), 32'd0);
        chk("rm_ack", 32'(dwb_ack), 32'd0);
        chk("rm_gnt0", 32'(arb_gnt), 32'd0);
        chk("rm_tmo", 32'(arb_tmo), 32'd0);
        step();
        sys_rst = 1'b0;
        #1;
        chk("rm_rel_gnt", 32'(arb_gnt), 32'd0);
        step();
        chk("rm_new_gnt", 32'(arb_gnt), 32'd2);
        chk("rm_new_adr", 32'(mwb_adr), 32'hA0);
        man_ack = 1'b1; mwb_dti = 32'hCAFE_0001;
        #1;
        chk("rm_new_ack", 32'(dwb_ack), 32'd1);
        chk("rm_new_dti", dwb_dti, 32'hCAFE_0001);
        step();
        man_ack = 1'b0; dwb_stb = 1'b0;
        #1;
        chk("rm_end_gnt", 32'(arb_gnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_t5_wbarb
